// File: rtl/core_regs_banked_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_regs_banked_pkg
// Description : Shared core types for the banked architectural register file.
//               Holds the word/ptr/reg_num types, the psr_mode encodings, the
//               PC register number, the physical register index type and the
//               (reg_num, psr_mode) -> physical entry banking function.
// Revision    : 1.0 - initial release
// ============================================================================
package core_regs_banked_pkg;

    typedef logic [31:0] word_t;
    typedef logic [29:0] ptr_t;
    typedef logic [3:0]  reg_num_t;

    typedef enum logic [4:0] {
        MODE_USR = 5'h10,
        MODE_FIQ = 5'h11,
        MODE_IRQ = 5'h12,
        MODE_SVC = 5'h13,
        MODE_ABT = 5'h17,
        MODE_UND = 5'h1B,
        MODE_SYS = 5'h1F
    } psr_mode_e;

    localparam reg_num_t REG_PC = 4'd15;

    // Bank 0 maps r0-r15 onto entries 0-15 by identity, so entry 15 is a
    // hole (r15 is never stored). FIQ bank follows, then four 2-entry
    // banks for IRQ/SVC/ABT/UND.
    function automatic int phys_count(input bit bank_fiq);
        return 16 + 7 * int'(bank_fiq) + 2 * (5 - int'(bank_fiq));
    endfunction

    localparam int PHYS_MAX = phys_count(1'b1);

    typedef logic [$clog2(PHYS_MAX)-1:0] phys_reg_num_t;

    function automatic phys_reg_num_t bank_map(
        input reg_num_t   r,
        input logic [4:0] mode,
        input bit         bank_fiq
    );
        int idx;
        int fiq_lo;
        int fiq_size;
        int slot;
        fiq_lo   = bank_fiq ? 8 : 13;
        fiq_size = bank_fiq ? 7 : 2;
        idx      = int'(r);
        slot     = -1;
        case (mode)
            MODE_FIQ: begin
                if (int'(r) >= fiq_lo && r != REG_PC) begin
                    idx = 16 + int'(r) - fiq_lo;
                end
            end
            MODE_IRQ: slot = 0;
            MODE_SVC: slot = 1;
            MODE_ABT: slot = 2;
            MODE_UND: slot = 3;
            default:  slot = -1;
        endcase
        if (slot >= 0 && (r == 4'd13 || r == 4'd14)) begin
            idx = 16 + fiq_size + 2 * slot + int'(r) - 13;
        end
        return phys_reg_num_t'(idx);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_regs_banked_if.sv
`default_nettype none
// ============================================================================
// Module      : core_regs_banked_if
// Description : Port bundle of the banked register file.
//               Read side : rd_r[NUM_READ], rd_mode -> rd_value[NUM_READ]
//               Write side: wr_r, wr_mode, wr_enable, wr_value -> wr_current
//               PC side   : pc_visible in, branch / branch_target out
//               Status    : ready (clear sequence finished)
//               master = core driving the file, slave = register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_regs_banked_if
    import core_regs_banked_pkg::*;
#(
    parameter int NUM_READ = 2,
    parameter int WORD_W   = 32
);
    reg_num_t [NUM_READ-1:0]              rd_r;
    logic [4:0]                           rd_mode;
    reg_num_t                             wr_r;
    logic [4:0]                           wr_mode;
    logic                                 wr_enable;
    logic [WORD_W-1:0]                    wr_value;
    logic [WORD_W-3:0]                    pc_visible;
    logic [NUM_READ-1:0][WORD_W-1:0]      rd_value;
    logic [WORD_W-1:0]                    wr_current;
    logic                                 branch;
    logic [WORD_W-3:0]                    branch_target;
    logic                                 ready;

    modport master (
        output rd_r, rd_mode, wr_r, wr_mode, wr_enable, wr_value, pc_visible,
        input  rd_value, wr_current, branch, branch_target, ready
    );

    modport slave (
        input  rd_r, rd_mode, wr_r, wr_mode, wr_enable, wr_value, pc_visible,
        output rd_value, wr_current, branch, branch_target, ready
    );
endinterface
`default_nettype wire

// File: rtl/core_regs_banked_copy.sv
`default_nettype none
// ============================================================================
// Module      : core_regs_banked_copy
// Description : One 1R1W RAM copy with registered (synchronous) read and
//               write-first bypass.
//               clk     in  clock
//               i_we    in  write strobe
//               i_waddr in  write entry
//               i_wdata in  write data
//               i_raddr in  read entry, sampled on posedge
//               o_rdata out read data, one cycle after i_raddr
// Revision    : 1.0 - initial release
// ============================================================================
module core_regs_banked_copy #(
    parameter int DEPTH  = 31,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [WORD_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [WORD_W-1:0] o_rdata
);
    // No reset on the array or read register: maps onto block RAM.
    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [WORD_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        // The array read sees the pre-write contents, so a same-edge write
        // to the read entry is forwarded explicitly.
        if (i_we && (i_waddr == i_raddr)) begin
            r_rdata <= i_wdata;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/core_regs_banked.sv
`default_nettype none
// ============================================================================
// Module      : core_regs_banked
// Description : Mode-banked architectural register file, NUM_READ read ports
//               and one write port. One RAM copy per read port, all written
//               in lockstep. r15 is not stored: reads return pc_visible and
//               writes raise a one-cycle branch. After reset a clear
//               sequencer zeroes every entry; ready rises when it finishes.
//               clk  in  clock
//               rst  in  synchronous active-high reset
//               bus  core_regs_banked_if.slave (see interface for signals)
// Revision    : 1.0 - initial release
// ============================================================================
module core_regs_banked
    import core_regs_banked_pkg::*;
#(
    parameter int NUM_READ = 2,
    parameter int WORD_W   = 32,
    parameter int BANK_FIQ = 1
) (
    input wire logic          clk,
    input wire logic          rst,
    core_regs_banked_if.slave bus
);
    localparam bit            c_bank_fiq = (BANK_FIQ != 0);
    localparam int            PHYS       = phys_count(c_bank_fiq);
    localparam phys_reg_num_t c_last_idx = phys_reg_num_t'(PHYS - 1);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]    r_state;
    logic [0:0]    w_state_nxt;
    phys_reg_num_t r_clr_idx;
    logic          w_clearing;
    logic          w_ready;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_idx == c_last_idx) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN:   w_state_nxt = S_RUN;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_comb begin
        w_clearing = 1'b0;
        w_ready    = 1'b0;
        case (r_state)
            S_CLEAR: w_clearing = 1'b1;
            S_RUN:   w_ready    = 1'b1;
            default: w_clearing = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clr_idx <= '0;
        end else if (w_clearing) begin
            r_clr_idx <= r_clr_idx + phys_reg_num_t'(1);
        end
    end

    // ---------------- write path ----------------
    logic              w_user_wr;
    logic              w_pc_wr;
    logic              w_ram_we;
    phys_reg_num_t     w_ram_waddr;
    logic [WORD_W-1:0] w_ram_wdata;

    assign w_user_wr   = w_ready & bus.wr_enable;
    assign w_pc_wr     = w_user_wr & (bus.wr_r == REG_PC);
    assign w_ram_we    = w_clearing | (w_user_wr & ~w_pc_wr);
    assign w_ram_waddr = w_clearing ? r_clr_idx
                                    : bank_map(bus.wr_r, bus.wr_mode, c_bank_fiq);
    assign w_ram_wdata = w_clearing ? '0 : bus.wr_value;

    logic              r_branch;
    logic [WORD_W-3:0] r_branch_target;
    logic [WORD_W-1:0] r_wr_current;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch        <= 1'b0;
            r_branch_target <= '0;
            r_wr_current    <= '0;
        end else begin
            // Re-evaluated every edge: back-to-back r15 writes keep it high.
            r_branch <= w_pc_wr;
            if (w_pc_wr) begin
                r_branch_target <= bus.wr_value[WORD_W-1:2];
            end
            if (w_user_wr) begin
                r_wr_current <= bus.wr_value;
            end
        end
    end

    assign bus.branch        = r_branch;
    assign bus.branch_target = r_branch_target;
    assign bus.wr_current    = r_wr_current;
    assign bus.ready         = w_ready;

    // ---------------- read path ----------------
    // r_rd_live masks RAM data for reads sampled during the clear sequence,
    // whose RAM output may still be uninitialised.
    logic                 r_rd_live;
    logic [NUM_READ-1:0]  r_rd_is_pc;
    logic [WORD_W-3:0]    r_pc;
    logic [WORD_W-1:0]    w_ram_q [NUM_READ];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_live  <= 1'b0;
            r_rd_is_pc <= '0;
            r_pc       <= '0;
        end else begin
            r_rd_live <= w_ready;
            r_pc      <= bus.pc_visible;
            for (int i = 0; i < NUM_READ; i++) begin
                r_rd_is_pc[i] <= (bus.rd_r[i] == REG_PC);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd_copy
            core_regs_banked_copy #(
                .DEPTH  (PHYS),
                .WORD_W (WORD_W),
                .ADDR_W ($bits(phys_reg_num_t))
            ) u_copy (
                .clk     (clk),
                .i_we    (w_ram_we),
                .i_waddr (w_ram_waddr),
                .i_wdata (w_ram_wdata),
                .i_raddr (bank_map(bus.rd_r[gi], bus.rd_mode, c_bank_fiq)),
                .o_rdata (w_ram_q[gi])
            );
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NUM_READ; i++) begin
            bus.rd_value[i] = '0;
            if (r_rd_live) begin
                bus.rd_value[i] = r_rd_is_pc[i] ? {r_pc, 2'b00} : w_ram_q[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_core_regs_banked.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_regs_banked
// Description : Directed self-checking bench for core_regs_banked
//               (NUM_READ=2, WORD_W=32, BANK_FIQ=1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_regs_banked;
    import core_regs_banked_pkg::*;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    core_regs_banked_if #(.NUM_READ(2), .WORD_W(32)) bus ();

    core_regs_banked #(
        .NUM_READ (2),
        .WORD_W   (32),
        .BANK_FIQ (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic [3:0] r, input logic [4:0] m, input logic [31:0] v);
        bus.wr_r      = r;
        bus.wr_mode   = m;
        bus.wr_value  = v;
        bus.wr_enable = 1'b1;
    endtask

    task automatic set_rd(input logic [4:0] m, input logic [3:0] r0, input logic [3:0] r1);
        bus.rd_mode  = m;
        bus.rd_r[0]  = r0;
        bus.rd_r[1]  = r1;
    endtask

    logic [4:0]  modes [7];
    logic [31:0] acc;
    logic [31:0] acc_br;
    int          cnt;

    initial begin
        modes[0] = MODE_USR; modes[1] = MODE_FIQ; modes[2] = MODE_IRQ;
        modes[3] = MODE_SVC; modes[4] = MODE_ABT; modes[5] = MODE_UND;
        modes[6] = MODE_SYS;

        rst            = 1'b1;
        bus.rd_r       = '0;
        bus.rd_mode    = MODE_USR;
        bus.wr_r       = 4'd0;
        bus.wr_mode    = MODE_USR;
        bus.wr_enable  = 1'b0;
        bus.wr_value   = 32'd0;
        bus.pc_visible = 30'h100;

        // ---- reset state ----
        tick;
        check("rst_ready",      32'(bus.ready), 32'd0);
        check("rst_rd0",        bus.rd_value[0], 32'd0);
        check("rst_rd1",        bus.rd_value[1], 32'd0);
        check("rst_wr_current", bus.wr_current, 32'd0);
        check("rst_branch",     32'(bus.branch), 32'd0);
        check("rst_target",     32'(bus.branch_target), 32'd0);
        rst = 1'b0;

        // ---- clear takes exactly 31 cycles ----
        cnt = 0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            cnt++;
            tick;
        end
        check("clear_cycles", 32'(cnt), 32'd31);

        // ---- every register in every mode reads 0 ----
        acc = '0;
        for (int m = 0; m < 7; m++) begin
            for (int r = 0; r < 15; r++) begin
                set_rd(modes[m], 4'(r), 4'(14 - r));
                tick;
                acc = acc | bus.rd_value[0] | bus.rd_value[1];
            end
        end
        check("clear_all_zero", acc, 32'd0);

        // ---- r13 banked in SVC ----
        set_wr(4'd13, MODE_SVC, 32'hDEAD_BEEF);
        tick;
        bus.wr_enable = 1'b0;
        check("svc_wr_current", bus.wr_current, 32'hDEAD_BEEF);
        set_rd(MODE_USR, 4'd13, 4'd14);
        tick;
        check("usr_r13", bus.rd_value[0], 32'd0);
        set_rd(MODE_SVC, 4'd13, 4'd14);
        tick;
        check("svc_r13", bus.rd_value[0], 32'hDEAD_BEEF);
        check("svc_r14", bus.rd_value[1], 32'd0);
        set_rd(MODE_IRQ, 4'd13, 4'd13);
        tick;
        check("irq_r13", bus.rd_value[0], 32'd0);

        // ---- FIQ r9: no bypass across banks ----
        set_wr(4'd9, MODE_FIQ, 32'h0000_1234);
        set_rd(MODE_USR, 4'd9, 4'd9);
        tick;
        bus.wr_enable = 1'b0;
        check("usr_r9_same_edge", bus.rd_value[0], 32'd0);
        set_rd(MODE_FIQ, 4'd9, 4'd13);
        tick;
        check("fiq_r9",  bus.rd_value[0], 32'h0000_1234);
        check("fiq_r13", bus.rd_value[1], 32'd0);

        // ---- same-bank bypass inside FIQ ----
        set_wr(4'd10, MODE_FIQ, 32'h0000_0055);
        set_rd(MODE_FIQ, 4'd10, 4'd9);
        tick;
        bus.wr_enable = 1'b0;
        check("fiq_r10_bypass", bus.rd_value[0], 32'h0000_0055);
        check("fiq_r9_again",   bus.rd_value[1], 32'h0000_1234);

        // ---- r3 write-first bypass on both ports (SYS shares USR bank) ----
        set_wr(4'd3, MODE_USR, 32'hA5A5_A5A5);
        set_rd(MODE_SYS, 4'd3, 4'd3);
        tick;
        bus.wr_enable = 1'b0;
        check("r3_bypass_p0", bus.rd_value[0], 32'hA5A5_A5A5);
        check("r3_bypass_p1", bus.rd_value[1], 32'hA5A5_A5A5);

        // ---- r8 is only banked for FIQ ----
        set_wr(4'd8, MODE_USR, 32'h0000_0088);
        tick;
        bus.wr_enable = 1'b0;
        set_rd(MODE_IRQ, 4'd8, 4'd14);
        tick;
        check("irq_r8", bus.rd_value[0], 32'h0000_0088);
        check("irq_r14", bus.rd_value[1], 32'd0);
        set_rd(MODE_FIQ, 4'd8, 4'd3);
        tick;
        check("fiq_r8", bus.rd_value[0], 32'd0);
        check("fiq_r3", bus.rd_value[1], 32'hA5A5_A5A5);

        // ---- undefined mode uses bank 0 ----
        set_wr(4'd13, 5'h00, 32'h0000_0077);
        tick;
        bus.wr_enable = 1'b0;
        set_rd(MODE_USR, 4'd13, 4'd13);
        tick;
        check("undef_mode_r13", bus.rd_value[0], 32'h0000_0077);

        // ---- r15 write -> branch, r15 read -> pc ----
        set_wr(4'd15, MODE_USR, 32'h0000_1004);
        set_rd(MODE_USR, 4'd15, 4'd3);
        tick;
        bus.wr_enable = 1'b0;
        check("br_pulse",      32'(bus.branch), 32'd1);
        check("br_target",     32'(bus.branch_target), 32'h0000_0401);
        check("br_wr_current", bus.wr_current, 32'h0000_1004);
        check("r15_read",      bus.rd_value[0], 32'h0000_0400);
        tick;
        check("br_one_cycle",  32'(bus.branch), 32'd0);

        // ---- back-to-back branch writes extend the pulse ----
        set_wr(4'd15, MODE_SVC, 32'h0000_2000);
        tick;
        check("br2_pulse",  32'(bus.branch), 32'd1);
        check("br2_target", 32'(bus.branch_target), 32'h0000_0800);
        set_wr(4'd15, MODE_SVC, 32'h0000_3008);
        tick;
        bus.wr_enable = 1'b0;
        check("br3_pulse",  32'(bus.branch), 32'd1);
        check("br3_target", 32'(bus.branch_target), 32'h0000_0C02);
        tick;
        check("br3_end", 32'(bus.branch), 32'd0);

        // ---- write strobe low: nothing accepted ----
        bus.wr_r     = 4'd4;
        bus.wr_value = 32'h0000_FFFF;
        set_rd(MODE_USR, 4'd4, 4'd4);
        tick;
        check("nowr_wr_current", bus.wr_current, 32'h0000_3008);
        check("nowr_r4", bus.rd_value[0], 32'd0);

        // ---- pc_visible sampled at the read edge ----
        set_rd(MODE_USR, 4'd3, 4'd15);
        bus.pc_visible = 30'h2AAA_AAAA;
        tick;
        bus.pc_visible = 30'h0;
        check("pc_sampled", bus.rd_value[1], 32'hAAAA_AAA8);

        // ---- reset mid-clear restarts; writes during clear ignored ----
        rst = 1'b1;
        tick;
        rst = 1'b0;
        repeat (10) tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_rd(MODE_USR, 4'd3, 4'd5);
        cnt    = 0;
        acc    = '0;
        acc_br = '0;
        while (bus.ready !== 1'b1 && cnt < 100) begin
            set_wr((cnt % 2 != 0) ? 4'd15 : 4'd5, MODE_USR, 32'hBAD0_0000 | 32'(cnt));
            acc    = acc | bus.rd_value[0] | bus.rd_value[1];
            acc_br = acc_br | 32'(bus.branch);
            cnt++;
            tick;
        end
        bus.wr_enable = 1'b0;
        acc_br = acc_br | 32'(bus.branch);
        check("reclear_cycles",  32'(cnt), 32'd31);
        check("reclear_branch",  acc_br, 32'd0);
        check("reclear_rd_zero", acc, 32'd0);
        check("reclear_wr_cur",  bus.wr_current, 32'd0);
        set_rd(MODE_USR, 4'd3, 4'd5);
        tick;
        check("reclear_r3", bus.rd_value[0], 32'd0);
        check("reclear_r5", bus.rd_value[1], 32'd0);
        set_rd(MODE_SVC, 4'd13, 4'd13);
        tick;
        check("reclear_svc_r13", bus.rd_value[0], 32'd0);

        // ---- ports live again after restart ----
        set_wr(4'd5, MODE_USR, 32'h0000_0005);
        set_rd(MODE_USR, 4'd5, 4'd5);
        tick;
        bus.wr_enable = 1'b0;
        check("post_r5", bus.rd_value[1], 32'h0000_0005);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
